debounce_multi: RTL and testbench

//  N-channel debouncer for raw pushbutton/switch inputs, successor to the single-channel debouncer.
//  Per channel: 2-FF synchroniser, optional inversion for active-low buttons, and a stable-time filter.

---
 rtl/debounce_pkg.sv | 11 +
 rtl/debounce_channel.sv | 77 +++++++
 rtl/debounce_multi.sv | 50 +++++
 tb/tb_debounce_multi.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and cycle-count helper for the debouncer family.
// Pure declarations; no latency or backpressure of its own.
package debounce_pkg;

    typedef enum logic {DB_LOW = 1'b0, DB_HIGH = 1'b1} db_state_t;

    function automatic int cycles_from_us(input longint freq, input longint us);
        return int'((freq / longint'(1_000_000)) * us);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounce channel: 2-FF sync, optional inversion, stable-time filter, edge and long-press pulses.
// Raw-to-level latency 2+DB_CYCLES cycles; no backpressure, all pulses are single-cycle and free-running.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DB_CYCLES   = 10,
    parameter int HOLD_CYCLES = 50,
    parameter bit INVERT      = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall,
    output logic hold
);

    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [1:0]    sync_q;
    logic          s;
    db_state_t     state;
    logic [CW-1:0] cnt;

    assign s     = sync_q[1] ^ INVERT;
    assign level = (state == DB_HIGH);

    // Any sample that agrees with the current state restarts the stability count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
            state  <= DB_LOW;
            cnt    <= '0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], raw};
            rise   <= 1'b0;
            fall   <= 1'b0;
            if (s == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DB_CYCLES - 1)) begin
                cnt   <= '0;
                state <= level ? DB_LOW : DB_HIGH;
                rise  <= !level;
                fall  <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    if (HOLD_CYCLES > 0) begin : g_hold
        localparam int HW = $clog2(HOLD_CYCLES + 1);
        logic [HW-1:0] hcnt;

        // Counter saturates at HOLD_CYCLES so the pulse fires once per press.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                hcnt <= '0;
                hold <= 1'b0;
            end else if (!level) begin
                hcnt <= '0;
                hold <= 1'b0;
            end else if (hcnt != HW'(HOLD_CYCLES)) begin
                hcnt <= hcnt + 1'b1;
                hold <= (hcnt == HW'(HOLD_CYCLES - 1));
            end else begin
                hold <= 1'b0;
            end
        end
    end else begin : g_no_hold
        assign hold = 1'b0;
    end

endmodule

// File: rtl/debounce_multi.sv
// N independent debounce channels with rise/fall/long-press pulses, sliced onto flat ports.
// Raw-to-db_out latency 2+DB_CYCLES cycles; no backpressure, outputs are free-running pulses/levels.
module debounce_multi
    import debounce_pkg::*;
#(
    parameter int                NUM_CH            = 4,
    parameter int                CLK_FREQUENCY     = 100_000_000,
    parameter int                DEBOUNCE_DELAY_US = 1_000,
    parameter int                HOLD_DELAY_US     = 500_000,
    parameter logic [NUM_CH-1:0] INVERT            = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] db_in,
    output logic [NUM_CH-1:0] db_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic [NUM_CH-1:0] hold_pulse
);

    localparam int DB_CYCLES   = cycles_from_us(CLK_FREQUENCY, DEBOUNCE_DELAY_US);
    localparam int HOLD_CYCLES = cycles_from_us(CLK_FREQUENCY, HOLD_DELAY_US);

    if (NUM_CH < 1) begin : g_err_num_ch
        $error("debounce_multi: NUM_CH must be at least 1");
    end
    if (DB_CYCLES < 1) begin : g_err_db_cycles
        $error("debounce_multi: debounce time must be at least one clock cycle");
    end
    if (CLK_FREQUENCY % 1_000_000 != 0) begin : g_err_freq
        $error("debounce_multi: CLK_FREQUENCY must be a whole number of MHz");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        debounce_channel #(
            .DB_CYCLES   (DB_CYCLES),
            .HOLD_CYCLES (HOLD_CYCLES),
            .INVERT      (INVERT[i])
        ) u_channel (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (db_in[i]),
            .level (db_out[i]),
            .rise  (rise_pulse[i]),
            .fall  (fall_pulse[i]),
            .hold  (hold_pulse[i])
        );
    end

endmodule

// File: tb/tb_debounce_multi.sv
// Directed bench for debounce_multi: window-based reference model checked every cycle plus literal timing checks.
module tb_debounce_multi;

    localparam int          DB   = 10;
    localparam int          H    = 50;
    localparam logic [1:0]  INV  = 2'b10;
    localparam int          MAXC = 3000;

    logic       clk;
    logic       rst_n;
    logic [1:0] db_in;
    logic [1:0] db_out, rise_pulse, fall_pulse, hold_pulse;

    int tests = 0;
    int fails = 0;

    debounce_multi #(
        .NUM_CH            (2),
        .CLK_FREQUENCY     (10_000_000),
        .DEBOUNCE_DELAY_US (1),
        .HOLD_DELAY_US     (5),
        .INVERT            (INV)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .db_in      (db_in),
        .db_out     (db_out),
        .rise_pulse (rise_pulse),
        .fall_pulse (fall_pulse),
        .hold_pulse (hold_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: per-edge history of inputs; a channel flips when the last DB
    // synchronised samples all differ from its level with no reset or flip inside that window.
    int         cyc = 0;
    logic [1:0] raw_h  [MAXC];
    bit         rst_h  [MAXC];
    logic [1:0] st_h   [MAXC];
    logic [1:0] rise_h [MAXC];
    logic [1:0] fall_h [MAXC];
    logic [1:0] hold_h [MAXC];
    logic [1:0] ev_h   [MAXC];

    function automatic logic s_at(input int e, input int ch);
        if (rst_h[e-1] || rst_h[e-2]) return INV[ch];
        return raw_h[e-2][ch] ^ INV[ch];
    endfunction

    initial begin
        raw_h[0] = '0; rst_h[0] = 1'b1; st_h[0] = '0;
        rise_h[0] = '0; fall_h[0] = '0; hold_h[0] = '0; ev_h[0] = '1;
        forever begin
            @(posedge clk);
            cyc++;
            if (cyc >= MAXC) begin
                $display("FAIL model_budget: got %0d cycles expected below %0d", cyc, MAXC);
                $fatal(1, "cycle budget exceeded");
            end
            raw_h[cyc] = db_in;
            rst_h[cyc] = !rst_n;
            for (int ch = 0; ch < 2; ch++) begin
                if (!rst_n) begin
                    st_h[cyc][ch] = 1'b0; rise_h[cyc][ch] = 1'b0;
                    fall_h[cyc][ch] = 1'b0; hold_h[cyc][ch] = 1'b0;
                    ev_h[cyc][ch] = 1'b1;
                end else begin
                    logic prev, flip, hr;
                    prev = st_h[cyc-1][ch];
                    flip = 1'b1;
                    for (int k = 0; k < DB; k++) begin
                        int e;
                        e = cyc - k;
                        if (e < 3) flip = 1'b0;
                        else if (k > 0 && ev_h[e][ch]) flip = 1'b0;
                        else if (s_at(e, ch) == prev) flip = 1'b0;
                    end
                    st_h[cyc][ch]   = flip ? ~prev : prev;
                    ev_h[cyc][ch]   = flip;
                    rise_h[cyc][ch] = flip & ~prev;
                    fall_h[cyc][ch] = flip & prev;
                    hr = 1'b0;
                    if (cyc > H) begin
                        hr = rise_h[cyc-H][ch];
                        for (int j = cyc - H; j < cyc; j++) hr = hr & st_h[j][ch];
                    end
                    hold_h[cyc][ch] = hr;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                check("db_out", db_out, st_h[cyc]);
                check("rise_pulse", rise_pulse, rise_h[cyc]);
                check("fall_pulse", fall_pulse, fall_h[cyc]);
                check("hold_pulse", hold_pulse, hold_h[cyc]);
            end
        end
    end

    int first_hi, nr, rise_at, nf, fall_at, nh, hold_at, seen;
    logic [1:0] rv;

    initial begin
        rst_n = 1'b0;
        db_in = 2'b11;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("reset_db_out", db_out, 0);
            check("reset_pulses", rise_pulse | fall_pulse | hold_pulse, 0);
        end
        rst_n = 1'b1;
        db_in = 2'b10;
        tick(20);

        // Clean press on channel 0, held 40 cycles.
        db_in[0] = 1'b1;
        first_hi = -1; nr = 0; rise_at = -1;
        for (int j = 1; j <= 40; j++) begin
            tick(1);
            if (db_out[0] && first_hi < 0) first_hi = j;
            if (rise_pulse[0]) begin nr++; rise_at = j; end
        end
        check("press_first_high", first_hi, 12);
        check("press_rise_count", nr, 1);
        check("press_rise_cycle", rise_at, 12);
        db_in[0] = 1'b0;
        nf = 0; fall_at = -1; nh = 0;
        for (int j = 1; j <= 30; j++) begin
            tick(1);
            if (fall_pulse[0]) begin nf++; fall_at = j; end
            if (hold_pulse[0]) nh++;
        end
        check("release_fall_cycle", fall_at, 12);
        check("release_fall_count", nf, 1);
        check("short_press_no_hold", nh, 0);

        // 9-cycle glitch must not pass.
        seen = 0;
        for (int j = 0; j < 40; j++) begin
            db_in[0] = (j < 9);
            tick(1);
            if (db_out[0] | rise_pulse[0] | fall_pulse[0]) seen++;
        end
        check("glitch_rejected", seen, 0);

        // Bounce, ending high, followed by a long press.
        for (int i = 0; i < 7; i++) begin
            db_in[0] = (i % 2 == 0);
            if (i < 6) tick(3);
        end
        nr = 0; rise_at = -1; nh = 0; hold_at = -1;
        for (int j = 1; j <= 120; j++) begin
            tick(1);
            if (rise_pulse[0]) begin nr++; rise_at = j; end
            if (hold_pulse[0]) begin nh++; hold_at = j; end
        end
        check("bounce_rise_count", nr, 1);
        check("bounce_rise_cycle", rise_at, 12);
        check("long_hold_count", nh, 1);
        check("long_hold_cycle", hold_at, 62);
        db_in[0] = 1'b0;
        nf = 0; fall_at = -1; nh = 0;
        for (int j = 1; j <= 40; j++) begin
            tick(1);
            if (fall_pulse[0]) begin nf++; fall_at = j; end
            if (hold_pulse[0]) nh++;
        end
        check("long_release_fall_cycle", fall_at, 12);
        check("long_release_no_hold", nh, 0);

        // Inverted channel 1: press is db_in[1] going low.
        db_in[1] = 1'b0;
        first_hi = -1;
        for (int j = 1; j <= 20; j++) begin
            tick(1);
            if (db_out[1] && first_hi < 0) first_hi = j;
        end
        check("inv_press_first_high", first_hi, 12);
        db_in[1] = 1'b1;
        tick(20);
        check("inv_released", db_out[1], 0);

        // Reset while the count sits at 7.
        db_in[1] = 1'b0;
        tick(9);
        rst_n = 1'b0;
        tick(1);
        check("midcount_reset_out", db_out, 0);
        rst_n = 1'b1;
        first_hi = -1;
        for (int j = 1; j <= 70; j++) begin
            tick(1);
            if (db_out[1] && first_hi < 0) first_hi = j;
        end
        check("post_reset_first_high", first_hi, 10);
        db_in[1] = 1'b1;
        tick(20);

        // Both channels at once.
        db_in = 2'b01;
        rise_at = -1; rv = '0;
        for (int j = 1; j <= 20; j++) begin
            tick(1);
            if (rise_pulse != 2'b00 && rise_at < 0) begin rise_at = j; rv = rise_pulse; end
        end
        check("both_rise_cycle", rise_at, 12);
        check("both_rise_value", rv, 2'b11);
        db_in = 2'b10;
        fall_at = -1; rv = '0;
        for (int j = 1; j <= 20; j++) begin
            tick(1);
            if (fall_pulse != 2'b00 && fall_at < 0) begin fall_at = j; rv = fall_pulse; end
        end
        check("both_fall_cycle", fall_at, 12);
        check("both_fall_value", rv, 2'b11);

        tick(5);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
